// File: rtl/instr_mem_pipe.sv
// ----------------------------------------------------------------------------
// instr_mem_pipe
//
// Pipelined instruction store for the fetch stage. One request is accepted on
// every rising edge where i_stb is high. There is no backpressure. The store
// is read in the first pipeline stage. The remaining stages only add delay, so
// a response leaves the last stage LATENCY edges after acceptance.
//
// Each fetch is classified when it is accepted:
//   - misaligned   : i_addr[1:0] != 0
//   - out of range : i_addr < BASE_ADDR, or i_addr - BASE_ADDR >= DEPTH_WORDS*4
// A faulty fetch answers with o_err=1 and o_data=0. The store contents are
// never shown for such a fetch.
//
// i_flush drops every response still in flight, output stage included. A
// request strobed on the same edge as the flush is still accepted.
//
// Ports
//   clk      in   1     system clock, rising edge
//   rst_n    in   1     asynchronous active-low reset (store is not reset)
//   i_addr   in   XLEN  byte fetch address
//   i_stb    in   1     request strobe
//   i_flush  in   1     discard all in-flight responses
//   o_ack    out  1     one-cycle response pulse per surviving request
//   o_data   out  XLEN  instruction word, zero whenever o_ack=0 or o_err=1
//   o_err    out  1     response is an error, only set together with o_ack
//   o_busy   out  1     some stage, output stage included, holds a request
// ----------------------------------------------------------------------------
module instr_mem_pipe #(
    parameter int unsigned        XLEN        = 32,
    parameter int unsigned        DEPTH_WORDS = 1024,
    parameter int unsigned        LATENCY     = 1,
    parameter logic [XLEN-1:0]    BASE_ADDR   = {XLEN{1'b0}},
    parameter string              INIT_FILE   = ""
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] i_addr,
    input  logic            i_stb,
    input  logic            i_flush,
    output logic            o_ack,
    output logic [XLEN-1:0] o_data,
    output logic            o_err,
    output logic            o_busy
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    // The address span is compared in XLEN+1 bits so that a large offset
    // cannot wrap back into the legal window.
    localparam logic [XLEN:0] SPAN_BYTES = (XLEN+1)'(DEPTH_WORDS) << 2;

    // Instruction store. It is never written at run time, and the reset does
    // not clear it. It starts zero-filled.
    logic [XLEN-1:0] mem_q [DEPTH_WORDS] = '{default: {XLEN{1'b0}}};

    // Per-stage state. Index LATENCY-1 is the output register.
    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] vld_d;
    logic [LATENCY-1:0] err_q;
    logic [LATENCY-1:0] err_d;
    logic [XLEN-1:0]    dat_q [LATENCY];
    logic [XLEN-1:0]    dat_d [LATENCY];

    logic [XLEN:0]      off_s;
    logic [AW-1:0]      idx_s;
    logic               bad_s;

    // Classify the incoming fetch and derive its word index.
    always_comb begin
        off_s = {1'b0, i_addr} - {1'b0, BASE_ADDR};
        idx_s = off_s[AW+1:2];
        // off_s[XLEN] is the borrow, which means i_addr lies below BASE_ADDR.
        bad_s = (i_addr[1:0] != 2'b00) || off_s[XLEN] || (off_s >= SPAN_BYTES);
    end

    // Next state of each stage. Stage 0 reads the store. Later stages shift,
    // and a flush clears them.
    always_comb begin
        vld_d = {LATENCY{1'b0}};
        err_d = {LATENCY{1'b0}};
        for (int j = 0; j < LATENCY; j++) begin
            dat_d[j] = {XLEN{1'b0}};
        end

        // A request taken on a flush edge is new, so it survives the flush.
        vld_d[0] = i_stb;
        err_d[0] = i_stb & bad_s;
        if (i_stb && !bad_s) begin
            dat_d[0] = mem_q[idx_s];
        end else begin
            dat_d[0] = {XLEN{1'b0}};
        end

        for (int j = 1; j < LATENCY; j++) begin
            if (i_flush) begin
                vld_d[j] = 1'b0;
                err_d[j] = 1'b0;
                dat_d[j] = {XLEN{1'b0}};
            end else begin
                vld_d[j] = vld_q[j-1];
                err_d[j] = err_q[j-1];
                dat_d[j] = dat_q[j-1];
            end
        end
    end

    // Stage registers. Data and error are cleared together with the valid
    // bit, so a dead stage never shows stale contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= {LATENCY{1'b0}};
            err_q <= {LATENCY{1'b0}};
            for (int j = 0; j < LATENCY; j++) begin
                dat_q[j] <= {XLEN{1'b0}};
            end
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
            for (int j = 0; j < LATENCY; j++) begin
                dat_q[j] <= dat_d[j];
            end
        end
    end

    // Drive the outputs directly from the output register.
    always_comb begin
        o_ack  = vld_q[LATENCY-1];
        o_err  = err_q[LATENCY-1];
        o_data = dat_q[LATENCY-1];
        o_busy = |vld_q;
    end

endmodule

// File: tb/tb_instr_mem_pipe.sv
// ----------------------------------------------------------------------------
// Testbench for instr_mem_pipe. Four instances share one stimulus stream:
//   u_l1 : LATENCY=1, BASE_ADDR=0
//   u_l3 : LATENCY=3, BASE_ADDR=0
//   u_l2 : LATENCY=2, BASE_ADDR=0
//   u_b  : LATENCY=1, BASE_ADDR=0x1000
// A reference model keeps a list of pending responses for each instance, and
// every cycle's outputs are compared against that model. Directed checks with
// literal values fix the key points of the timeline.
// ----------------------------------------------------------------------------
module tb_instr_mem_pipe;

    localparam int NI = 4;
    localparam int LAT_C  [NI] = '{1, 3, 2, 1};
    localparam longint BASE_C [NI] = '{64'h0, 64'h0, 64'h0, 64'h1000};
    localparam longint SPAN = 64'd4096;

    logic        clk;
    logic        rst_n;
    logic [31:0] i_addr;
    logic        i_stb;
    logic        i_flush;

    logic        ack_s  [NI];
    logic [31:0] data_s [NI];
    logic        err_s  [NI];
    logic        busy_s [NI];

    instr_mem_pipe #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h0000_0000)) u_l1 (
        .clk(clk), .rst_n(rst_n), .i_addr(i_addr), .i_stb(i_stb), .i_flush(i_flush),
        .o_ack(ack_s[0]), .o_data(data_s[0]), .o_err(err_s[0]), .o_busy(busy_s[0]));
    instr_mem_pipe #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(3), .BASE_ADDR(32'h0000_0000)) u_l3 (
        .clk(clk), .rst_n(rst_n), .i_addr(i_addr), .i_stb(i_stb), .i_flush(i_flush),
        .o_ack(ack_s[1]), .o_data(data_s[1]), .o_err(err_s[1]), .o_busy(busy_s[1]));
    instr_mem_pipe #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) u_l2 (
        .clk(clk), .rst_n(rst_n), .i_addr(i_addr), .i_stb(i_stb), .i_flush(i_flush),
        .o_ack(ack_s[2]), .o_data(data_s[2]), .o_err(err_s[2]), .o_busy(busy_s[2]));
    instr_mem_pipe #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h0000_1000)) u_b (
        .clk(clk), .rst_n(rst_n), .i_addr(i_addr), .i_stb(i_stb), .i_flush(i_flush),
        .o_ack(ack_s[3]), .o_data(data_s[3]), .o_err(err_s[3]), .o_busy(busy_s[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int edge_n = 0;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } resp_t;

    resp_t pend_q [NI][$];

    // Store image: three known instructions, then 0xCAFE0000 | index.
    function automatic logic [31:0] word_of(input int i);
        case (i)
            0:       word_of = 32'h0000_0013;
            1:       word_of = 32'h0010_0093;
            2:       word_of = 32'h0020_0113;
            default: word_of = 32'hCAFE_0000 | 32'(i);
        endcase
    endfunction

    function automatic resp_t model_resp(input int inst, input logic [31:0] addr, input int due);
        resp_t  r;
        longint a;
        longint off;
        a     = longint'(addr);
        off   = a - BASE_C[inst];
        r.due = due;
        r.err = ((a % 4) != 0) || (off < 0) || (off >= SPAN);
        r.data = r.err ? 32'h0 : word_of(int'(off / 4));
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic step(input logic s, input logic [31:0] a, input logic f);
        @(negedge clk);
        i_stb   = s;
        i_addr  = a;
        i_flush = f;
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            step(1'b0, 32'h0, 1'b0);
        end
    endtask

    // Model update: on each rising edge, record accepted requests and apply flushes.
    initial begin
        forever begin
            @(posedge clk);
            edge_n++;
            for (int i = 0; i < NI; i++) begin
                if (!rst_n) begin
                    pend_q[i].delete();
                end else begin
                    if (i_flush) pend_q[i].delete();
                    if (i_stb) pend_q[i].push_back(model_resp(i, i_addr, edge_n + LAT_C[i] - 1));
                end
            end
        end
    end

    // Per-cycle comparison of every instance against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                logic        e_ack;
                logic        e_err;
                logic [31:0] e_dat;
                logic        e_busy;
                e_ack  = 1'b0;
                e_err  = 1'b0;
                e_dat  = 32'h0;
                e_busy = (pend_q[i].size() > 0);
                if (pend_q[i].size() > 0 && pend_q[i][0].due == edge_n) begin
                    e_ack = 1'b1;
                    e_err = pend_q[i][0].err;
                    e_dat = pend_q[i][0].data;
                    void'(pend_q[i].pop_front());
                end
                chk($sformatf("cyc%0d u%0d ack", edge_n, i), 32'(ack_s[i]), 32'(e_ack));
                chk($sformatf("cyc%0d u%0d err", edge_n, i), 32'(err_s[i]), 32'(e_err));
                chk($sformatf("cyc%0d u%0d data", edge_n, i), data_s[i], e_dat);
                chk($sformatf("cyc%0d u%0d busy", edge_n, i), 32'(busy_s[i]), 32'(e_busy));
            end
        end
    end

    // Directed stimulus with literal expectations.
    initial begin
        rst_n   = 1'b0;
        i_stb   = 1'b0;
        i_addr  = 32'h0;
        i_flush = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            u_l1.mem_q[i] = word_of(i);
            u_l3.mem_q[i] = word_of(i);
            u_l2.mem_q[i] = word_of(i);
            u_b.mem_q[i]  = word_of(i);
        end

        // Reset state.
        idle(2);
        chk("reset ack", 32'(ack_s[0]), 32'h0);
        chk("reset data", data_s[0], 32'h0);
        chk("reset busy", 32'(busy_s[1]), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch with LATENCY=1.
        step(1'b1, 32'h0, 1'b0);
        step(1'b1, 32'h4, 1'b0);
        chk("seq ack0", 32'(ack_s[0]), 32'h1);
        chk("seq data0", data_s[0], 32'h0000_0013);
        step(1'b1, 32'h8, 1'b0);
        chk("seq data1", data_s[0], 32'h0010_0093);
        step(1'b0, 32'h0, 1'b0);
        chk("seq data2", data_s[0], 32'h0020_0113);
        chk("seq err2", 32'(err_s[0]), 32'h0);
        step(1'b0, 32'h0, 1'b0);
        chk("seq ack idle", 32'(ack_s[0]), 32'h0);
        idle(3);

        // Misaligned fetch, followed by a good one.
        step(1'b1, 32'h9, 1'b0);
        step(1'b1, 32'hC, 1'b0);
        chk("misal ack", 32'(ack_s[0]), 32'h1);
        chk("misal err", 32'(err_s[0]), 32'h1);
        chk("misal data", data_s[0], 32'h0);
        step(1'b0, 32'h0, 1'b0);
        chk("after misal err", 32'(err_s[0]), 32'h0);
        chk("after misal data", data_s[0], 32'hCAFE_0003);
        idle(3);

        // Range limits, with base 0 (u_l1) and with base 0x1000 (u_b).
        step(1'b1, 32'h0000_0FFC, 1'b0);
        step(1'b1, 32'h0000_1000, 1'b0);
        chk("top word data", data_s[0], 32'hCAFE_03FF);
        chk("top word err", 32'(err_s[0]), 32'h0);
        chk("below base err", 32'(err_s[3]), 32'h1);
        step(1'b1, 32'h0000_1FFC, 1'b0);
        chk("past top err", 32'(err_s[0]), 32'h1);
        chk("past top data", data_s[0], 32'h0);
        chk("base word data", data_s[3], 32'h0000_0013);
        step(1'b1, 32'h0000_2000, 1'b0);
        chk("base top data", data_s[3], 32'hCAFE_03FF);
        step(1'b1, 32'hFFFF_FFFC, 1'b0);
        chk("base past top err", 32'(err_s[3]), 32'h1);
        step(1'b0, 32'h0, 1'b0);
        chk("wrap err", 32'(err_s[3]), 32'h1);
        idle(4);

        // LATENCY=3 streaming of five back-to-back requests.
        step(1'b1, 32'h0, 1'b0);
        step(1'b1, 32'h4, 1'b0);
        chk("l3 busy early", 32'(busy_s[1]), 32'h1);
        chk("l3 no ack early", 32'(ack_s[1]), 32'h0);
        step(1'b1, 32'h8, 1'b0);
        chk("l3 no ack 2", 32'(ack_s[1]), 32'h0);
        step(1'b1, 32'hC, 1'b0);
        chk("l3 first ack", 32'(ack_s[1]), 32'h1);
        chk("l3 first data", data_s[1], 32'h0000_0013);
        step(1'b1, 32'h10, 1'b0);
        idle(3);
        chk("l3 last data", data_s[1], 32'hCAFE_0004);
        chk("l3 busy last", 32'(busy_s[1]), 32'h1);
        idle(1);
        chk("l3 busy drop", 32'(busy_s[1]), 32'h0);
        chk("l3 ack drop", 32'(ack_s[1]), 32'h0);
        idle(2);

        // Flush in mid-flight, with a request on the flush edge.
        step(1'b1, 32'h0, 1'b0);
        step(1'b1, 32'h4, 1'b0);
        step(1'b1, 32'h8, 1'b0);
        step(1'b1, 32'h40, 1'b1);
        chk("fl pre ack", 32'(ack_s[1]), 32'h1);
        step(1'b0, 32'h0, 1'b0);
        chk("fl l3 dropped", 32'(ack_s[1]), 32'h0);
        chk("fl l1 new data", data_s[0], 32'hCAFE_0010);
        step(1'b0, 32'h0, 1'b0);
        chk("fl l3 dropped2", 32'(ack_s[1]), 32'h0);
        step(1'b0, 32'h0, 1'b0);
        chk("fl l3 ack", 32'(ack_s[1]), 32'h1);
        chk("fl l3 data", data_s[1], 32'hCAFE_0010);
        step(1'b0, 32'h0, 1'b0);
        chk("fl l3 idle", 32'(busy_s[1]), 32'h0);
        idle(2);

        // Reset while requests are in flight.
        step(1'b1, 32'h0, 1'b0);
        step(1'b1, 32'h4, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        chk("rst pre ack", 32'(ack_s[2]), 32'h1);
        chk("rst pre busy", 32'(busy_s[2]), 32'h1);
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) pend_q[i].delete();
        #1;
        chk("rst ack now", 32'(ack_s[2]), 32'h0);
        chk("rst busy now", 32'(busy_s[2]), 32'h0);
        chk("rst data now", data_s[2], 32'h0);
        chk("rst l3 busy now", 32'(busy_s[1]), 32'h0);
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        chk("post rst quiet", 32'(busy_s[2]), 32'h0);
        step(1'b1, 32'h8, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        chk("post rst no ack yet", 32'(ack_s[2]), 32'h0);
        step(1'b0, 32'h0, 1'b0);
        chk("post rst ack", 32'(ack_s[2]), 32'h1);
        chk("post rst data", data_s[2], 32'h0020_0113);
        idle(4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
